// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver with mid-bit sampling.
// Optional even parity (8E1) is enabled by defining UART_RX_PARITY_EN; the port list
// is the same in both builds and parity_err is tied low when the macro is undefined.
module uart_rx_sampler #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [15:0] BitEnd  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfEnd = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM: centre-samples each bit and produces single-cycle result pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= 16'd0;
      idx        <= 3'd0;
      sh         <= 8'd0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        StIdle: begin
          if (!rx_s) begin
            state <= StStart;
            cnt   <= 16'd0;
          end
        end
        StStart: begin
          if (cnt == HalfEnd) begin
            cnt <= 16'd0;
            idx <= 3'd0;
            // A start bit that is high again at its centre was a glitch.
            state <= rx_s ? StIdle : StData;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StData: begin
          if (cnt == BitEnd) begin
            cnt <= 16'd0;
            sh  <= {rx_s, sh[7:1]};
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= StParity;
`else
              state <= StStop;
`endif
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt == BitEnd) begin
            cnt     <= 16'd0;
            // Even parity: data bits plus parity bit must hold an even count of ones.
            par_bad <= rx_s ^ (^sh);
            state   <= StStop;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        StStop: begin
          if (cnt == BitEnd) begin
            cnt <= 16'd0;
            if (rx_s) begin
              state <= StIdle;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                data_out   <= sh;
                data_valid <= 1'b1;
              end
`else
              data_out   <= sh;
              data_valid <= 1'b1;
`endif
            end else begin
              // Framing error takes precedence over any parity error.
              frame_err <= 1'b1;
              state     <= StBreak;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StBreak: begin
          // Hold off until the line is released so a stuck-low line cannot retrigger.
          if (rx_s) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Busy in every state except idle.
  assign busy = (state != StIdle);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed bench for uart_rx_sampler with CLKS_PER_BIT = 16.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_sampler;

  localparam int unsigned Cpb = 16;
`ifdef UART_RX_PARITY_EN
  localparam int Lat = 2 + Cpb / 2 + 10 * Cpb + 1;
`else
  localparam int Lat = 2 + Cpb / 2 + 9 * Cpb + 1;
`endif

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_sampler #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_dv = 0;
  int         n_fe = 0;
  int         n_pe = 0;
  int         n_busy = 0;
  int         n_bad = 0;
  int         last_dv_cyc = 0;
  int         start_cyc = 0;
  logic [7:0] dv_log[$];
  logic       prev_dv = 1'b0;
  logic       prev_fe = 1'b0;
  logic       prev_pe = 1'b0;

  // Monitor: samples 2 time units after each rising edge, counts pulses and flags
  // pulses that overlap or last more than one cycle.
  always @(posedge clock) begin
    #2;
    cyc = cyc + 1;
    if (data_valid) begin
      n_dv = n_dv + 1;
      dv_log.push_back(data_out);
      last_dv_cyc = cyc;
    end
    if (frame_err) n_fe = n_fe + 1;
    if (parity_err) n_pe = n_pe + 1;
    if (busy) n_busy = n_busy + 1;
    if ((int'(data_valid) + int'(frame_err) + int'(parity_err)) > 1) n_bad = n_bad + 1;
    if ((data_valid && prev_dv) || (frame_err && prev_fe) || (parity_err && prev_pe))
      n_bad = n_bad + 1;
    prev_dv = data_valid;
    prev_fe = frame_err;
    prev_pe = parity_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp)
    else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    ticks(Cpb);
  endtask

  // Full frame with correct parity (when enabled) and the given stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_v);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(~(^b));
    drive_bit(1'b1);
  endtask
`endif

  int b0;
  int dv0;

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    ticks(3);
    reset = 1'b0;

    // Reset state
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Idle line for 200 cycles
    b0 = n_busy;
    ticks(200);
    chk("idle_busy_cycles", 32'(n_busy - b0), 32'h0);
    chk("idle_pulses", 32'(n_dv + n_fe + n_pe), 32'h0);

    // Good frame 0xAA with exact latency
    send_frame(8'hAA, 1'b1);
    ticks(4);
    chk("good_dv_count", 32'(n_dv), 32'd1);
    chk("good_data", 32'(data_out), 32'hAA);
    chk("good_latency", 32'(last_dv_cyc - start_cyc), 32'(Lat));
    chk("good_busy_after", 32'(busy), 32'h0);

    // Glitch: 4 low cycles; busy rises on the third edge after the fall
    rx = 1'b0;
    ticks(2);
    chk("glitch_busy_pre", 32'(busy), 32'h0);
    ticks(1);
    chk("glitch_busy_rise", 32'(busy), 32'h1);
    ticks(1);
    rx = 1'b1;
    ticks(20);
    chk("glitch_busy_idle", 32'(busy), 32'h0);
    chk("glitch_no_pulse", 32'(n_dv + n_fe + n_pe), 32'd1);
    send_frame(8'h55, 1'b1);
    ticks(4);
    chk("after_glitch_dv", 32'(n_dv), 32'd2);
    chk("after_glitch_data", 32'(data_out), 32'h55);

    // Framing error: stop bit low, then line held low for 40 cycles
    send_frame(8'h3C, 1'b0);
    ticks(40);
    chk("ferr_count", 32'(n_fe), 32'd1);
    chk("ferr_data_kept", 32'(data_out), 32'h55);
    chk("ferr_no_dv", 32'(n_dv), 32'd2);
    chk("ferr_break_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    ticks(6);
    chk("ferr_release_idle", 32'(busy), 32'h0);
    chk("ferr_no_retrigger", 32'(n_fe + n_dv + n_pe), 32'd3);

    // Reset during data bit 4 of 0xF0, then a clean 0x0F
    dv0 = n_dv;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    ticks(8);
    reset = 1'b1;
    ticks(1);
    reset = 1'b0;
    chk("midrst_data_out", 32'(data_out), 32'h00);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_pulses", 32'({data_valid, frame_err, parity_err}), 32'h0);
    ticks(40);
    send_frame(8'h0F, 1'b1);
    ticks(4);
    chk("midrst_dv_count", 32'(n_dv - dv0), 32'd1);
    chk("midrst_data", 32'(data_out), 32'h0F);

    // Back-to-back frames with no idle gap
    dv0 = n_dv;
    send_frame(8'h81, 1'b1);
    send_frame(8'h7E, 1'b1);
    ticks(4);
    chk("b2b_dv_count", 32'(n_dv - dv0), 32'd2);
    chk("b2b_first", 32'(dv_log[dv_log.size() - 2]), 32'h81);
    chk("b2b_second", 32'(dv_log[dv_log.size() - 1]), 32'h7E);
    chk("b2b_latency", 32'(last_dv_cyc - start_cyc), 32'(Lat));

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity bit is 1
    dv0 = n_dv;
    send_frame(8'h07, 1'b1);
    ticks(4);
    chk("par_good_dv", 32'(n_dv - dv0), 32'd1);
    chk("par_good_data", 32'(data_out), 32'h07);
    chk("par_good_no_perr", 32'(n_pe), 32'd0);
    send_bad_parity(8'h07);
    ticks(4);
    chk("par_bad_perr", 32'(n_pe), 32'd1);
    chk("par_bad_no_dv", 32'(n_dv - dv0), 32'd1);
    chk("par_bad_data_kept", 32'(data_out), 32'h07);
`else
    chk("noparity_perr_tied", 32'(n_pe), 32'd0);
`endif

    chk("pulse_shape", 32'(n_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
